// File: rtl/pipe_ctrl_if.sv
`default_nettype none
//------------------------------------------------------------------------------
//  Module      : pipe_ctrl_if
//  Description : Bundle between the pipeline sequencer and the five-stage
//                core: stall requests, branch resolution and fetch status in;
//                hold/bubble controls, PC redirect and perf counters out.
//  Revision    : 1.0  initial release
//------------------------------------------------------------------------------
interface pipe_ctrl_if;
    logic        rdy;
    logic        if_stall_req;
    logic        id_stall_req;
    logic        ex_stall_req;
    logic        mem_stall_req;
    logic        ex_branch_taken;
    logic [31:0] ex_branch_target;
    logic        if_busy;
    logic [4:0]  stall;
    logic        flush_if_id;
    logic        flush_id_ex;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        if_discard;
    logic [31:0] stall_cnt;
    logic [31:0] flush_cnt;

    // Core side: drives requests, consumes controls
    modport master (
        output rdy, if_stall_req, id_stall_req, ex_stall_req, mem_stall_req,
               ex_branch_taken, ex_branch_target, if_busy,
        input  stall, flush_if_id, flush_id_ex, redirect_valid, redirect_pc,
               if_discard, stall_cnt, flush_cnt
    );

    // Sequencer side
    modport slave (
        input  rdy, if_stall_req, id_stall_req, ex_stall_req, mem_stall_req,
               ex_branch_taken, ex_branch_target, if_busy,
        output stall, flush_if_id, flush_id_ex, redirect_valid, redirect_pc,
               if_discard, stall_cnt, flush_cnt
    );
endinterface
`default_nettype wire

// File: rtl/pipe_ctrl.sv
`default_nettype none
//------------------------------------------------------------------------------
//  Module      : pipe_ctrl
//  Description : Central pipeline sequencer. Derives per-register hold and
//                bubble controls from stage stall requests, owns branch
//                redirection (deferred while a fetch is in flight) and keeps
//                stall/flush performance counters.
//  Revision    : 1.0  initial release
//------------------------------------------------------------------------------
module pipe_ctrl (
    input  wire logic  clk,
    input  wire logic  rst,
    pipe_ctrl_if.slave bus
);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_PEND = 1'b1;

    logic [0:0]  r_state;
    logic        r_redirect_valid;
    logic        r_if_discard;
    logic [31:0] r_redirect_pc;
    logic [31:0] r_stall_cnt;
    logic [31:0] r_flush_cnt;

    logic [4:0]  w_req_stall;
    logic        w_if_bubble;
    logic        w_id_bubble;
    logic        w_pend;
    logic [4:0]  w_stall;
    logic        w_accept;
    logic        w_flush_if_id;
    logic        w_flush_id_ex;
    logic [0:0]  w_state_nxt;
    logic        w_valid_nxt;

    assign w_pend = (r_state == ST_PEND);

    // Deepest requesting stage wins: it and everything upstream of it hold
    always_comb begin
        w_req_stall = 5'b00000;
        w_if_bubble = 1'b0;
        w_id_bubble = 1'b0;
        if (bus.mem_stall_req) begin
            w_req_stall = 5'b01111;
        end else if (bus.ex_stall_req) begin
            w_req_stall = 5'b00111;
        end else if (bus.id_stall_req) begin
            w_req_stall = 5'b00011;
            w_id_bubble = 1'b1;
        end else if (bus.if_stall_req) begin
            w_req_stall = 5'b00001;
            w_if_bubble = 1'b1;
        end
    end

    // Hold/bubble outputs and branch acceptance; rdy=0 freezes everything
    always_comb begin
        w_stall       = 5'b11111;
        w_accept      = 1'b0;
        w_flush_if_id = 1'b0;
        w_flush_id_ex = 1'b0;
        if (bus.rdy) begin
            // A pending redirect keeps the PC parked until the stale fetch returns
            w_stall       = w_req_stall | {4'b0000, w_pend};
            // A branch in a held EX stage is re-presented later, so ignore it now
            w_accept      = bus.ex_branch_taken && !w_stall[2];
            w_flush_if_id = w_if_bubble | w_accept | w_pend;
            w_flush_id_ex = w_id_bubble | w_accept;
        end
    end

    // Redirect sequencing: issue immediately if fetch is idle, else wait in PEND
    always_comb begin
        w_state_nxt = r_state;
        w_valid_nxt = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_valid_nxt = w_accept && !bus.if_busy;
                if (w_accept && bus.if_busy) begin
                    w_state_nxt = ST_PEND;
                end
            end
            ST_PEND: begin
                w_valid_nxt = !bus.if_busy;
                if (!bus.if_busy) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // State, redirect target and counters advance only while the core runs
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state          <= ST_IDLE;
            r_redirect_valid <= 1'b0;
            r_if_discard     <= 1'b0;
            r_redirect_pc    <= 32'd0;
            r_stall_cnt      <= 32'd0;
            r_flush_cnt      <= 32'd0;
        end else if (bus.rdy) begin
            r_state          <= w_state_nxt;
            r_redirect_valid <= w_valid_nxt;
            r_if_discard     <= (w_state_nxt == ST_PEND);
            if (w_accept) begin
                r_redirect_pc <= bus.ex_branch_target;
                r_flush_cnt   <= r_flush_cnt + 32'd1;
            end
            if (w_stall[0]) begin
                r_stall_cnt <= r_stall_cnt + 32'd1;
            end
        end
    end

    assign bus.stall          = w_stall;
    assign bus.flush_if_id    = w_flush_if_id;
    assign bus.flush_id_ex    = w_flush_id_ex;
    // A pulse registered just before a freeze is delivered once rdy returns
    assign bus.redirect_valid = r_redirect_valid & bus.rdy;
    assign bus.redirect_pc    = r_redirect_pc;
    assign bus.if_discard     = r_if_discard;
    assign bus.stall_cnt      = r_stall_cnt;
    assign bus.flush_cnt      = r_flush_cnt;

endmodule
`default_nettype wire

// File: tb/tb_pipe_ctrl.sv
`default_nettype none
//------------------------------------------------------------------------------
//  Module      : tb_pipe_ctrl
//  Description : Self-checking bench for pipe_ctrl. Scenario tasks check the
//                combinational controls inline; a scoreboard queue holds the
//                expected redirect targets, popped on every redirect pulse.
//  Revision    : 1.0  initial release
//------------------------------------------------------------------------------
module tb_pipe_ctrl;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    pipe_ctrl_if bus();

    pipe_ctrl dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int          errors = 0;
    int          checks = 0;
    logic [31:0] exp_q[$];
    logic [31:0] exp_scnt = 32'd0;
    logic [31:0] exp_fcnt = 32'd0;

    // Scoreboard: every redirect pulse must match the oldest expected target
    always @(negedge clk) begin
        if (bus.redirect_valid === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL sb_unexpected_redirect: got pulse pc=%h, expected no pulse", bus.redirect_pc);
            end else begin
                logic [31:0] t;
                t = exp_q.pop_front();
                if (bus.redirect_pc !== t) begin
                    errors++;
                    $display("FAIL sb_redirect_pc: got %h, expected %h", bus.redirect_pc, t);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic idle_inputs();
        bus.rdy              = 1'b1;
        bus.if_stall_req     = 1'b0;
        bus.id_stall_req     = 1'b0;
        bus.ex_stall_req     = 1'b0;
        bus.mem_stall_req    = 1'b0;
        bus.ex_branch_taken  = 1'b0;
        bus.ex_branch_target = 32'd0;
        bus.if_busy          = 1'b0;
    endtask

    // One clock edge with rdy=1; the model counters follow the expected activity
    task automatic cyc(input bit s0, input bit acc);
        @(posedge clk);
        if (s0)  exp_scnt = exp_scnt + 32'd1;
        if (acc) exp_fcnt = exp_fcnt + 32'd1;
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, got, exp);
        end
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        chk("rst_stall",       {27'd0, bus.stall}, 32'd0);
        chk("rst_flush_if_id", {31'd0, bus.flush_if_id}, 32'd0);
        chk("rst_flush_id_ex", {31'd0, bus.flush_id_ex}, 32'd0);
        chk("rst_redirect_v",  {31'd0, bus.redirect_valid}, 32'd0);
        chk("rst_redirect_pc", bus.redirect_pc, 32'd0);
        chk("rst_if_discard",  {31'd0, bus.if_discard}, 32'd0);
        chk("rst_stall_cnt",   bus.stall_cnt, 32'd0);
        chk("rst_flush_cnt",   bus.flush_cnt, 32'd0);
        cyc(0, 0);
    endtask

    task automatic test_stall_priority();
        bus.mem_stall_req = 1'b1; bus.id_stall_req = 1'b1; bus.if_stall_req = 1'b1;
        #1;
        chk("prio_mem_stall", {27'd0, bus.stall}, 32'h0F);
        chk("prio_mem_fid",   {31'd0, bus.flush_id_ex}, 32'd0);
        chk("prio_mem_fif",   {31'd0, bus.flush_if_id}, 32'd0);
        cyc(1, 0);
        bus.mem_stall_req = 1'b0;
        #1;
        chk("prio_id_stall", {27'd0, bus.stall}, 32'h03);
        chk("prio_id_fid",   {31'd0, bus.flush_id_ex}, 32'd1);
        chk("prio_id_fif",   {31'd0, bus.flush_if_id}, 32'd0);
        cyc(1, 0);
        bus.id_stall_req = 1'b0; bus.if_stall_req = 1'b0; bus.ex_stall_req = 1'b1;
        #1;
        chk("prio_ex_stall", {27'd0, bus.stall}, 32'h07);
        chk("prio_ex_fid",   {31'd0, bus.flush_id_ex}, 32'd0);
        cyc(1, 0);
        bus.ex_stall_req = 1'b0; bus.if_stall_req = 1'b1;
        #1;
        chk("prio_if_stall", {27'd0, bus.stall}, 32'h01);
        chk("prio_if_fif",   {31'd0, bus.flush_if_id}, 32'd1);
        chk("prio_if_fid",   {31'd0, bus.flush_id_ex}, 32'd0);
        cyc(1, 0);
        bus.if_stall_req = 1'b0;
        #1;
        chk("prio_none_stall", {27'd0, bus.stall}, 32'd0);
        chk("prio_stall_cnt",  bus.stall_cnt, exp_scnt);
        cyc(0, 0);
    endtask

    task automatic test_branch_idle();
        bus.ex_branch_taken = 1'b1; bus.ex_branch_target = 32'h0000_1000; bus.if_busy = 1'b0;
        #1;
        chk("br_fif", {31'd0, bus.flush_if_id}, 32'd1);
        chk("br_fid", {31'd0, bus.flush_id_ex}, 32'd1);
        exp_q.push_back(32'h0000_1000);
        cyc(0, 1);
        bus.ex_branch_taken = 1'b0;
        #1;
        chk("br_valid",     {31'd0, bus.redirect_valid}, 32'd1);
        chk("br_pc",        bus.redirect_pc, 32'h0000_1000);
        chk("br_flush_cnt", bus.flush_cnt, exp_fcnt);
        cyc(0, 0);
        chk("br_valid_once", {31'd0, bus.redirect_valid}, 32'd0);
    endtask

    task automatic test_branch_pend();
        bus.ex_branch_taken = 1'b1; bus.ex_branch_target = 32'h0000_2000; bus.if_busy = 1'b1;
        #1;
        chk("pend_fid", {31'd0, bus.flush_id_ex}, 32'd1);
        exp_q.push_back(32'h0000_2000);
        cyc(0, 1);
        bus.ex_branch_taken = 1'b0;
        for (int i = 0; i < 3; i++) begin
            if (i == 2) bus.if_busy = 1'b0;
            #1;
            chk("pend_discard", {31'd0, bus.if_discard}, 32'd1);
            chk("pend_pc_hold", {31'd0, bus.stall[0]}, 32'd1);
            chk("pend_fif",     {31'd0, bus.flush_if_id}, 32'd1);
            chk("pend_no_valid", {31'd0, bus.redirect_valid}, 32'd0);
            cyc(1, 0);
        end
        chk("pend_valid",      {31'd0, bus.redirect_valid}, 32'd1);
        chk("pend_pc",         bus.redirect_pc, 32'h0000_2000);
        chk("pend_discard_off", {31'd0, bus.if_discard}, 32'd0);
        cyc(0, 0);
        chk("pend_valid_once", {31'd0, bus.redirect_valid}, 32'd0);
    endtask

    task automatic test_pend_overwrite();
        bus.ex_branch_taken = 1'b1; bus.ex_branch_target = 32'h0000_3000; bus.if_busy = 1'b1;
        cyc(0, 1);
        bus.ex_branch_target = 32'h0000_4000;
        #1;
        chk("ovr_accept_fid", {31'd0, bus.flush_id_ex}, 32'd1);
        cyc(1, 1);
        bus.ex_branch_taken = 1'b0; bus.if_busy = 1'b0;
        exp_q.push_back(32'h0000_4000);
        #1;
        chk("ovr_no_early", {31'd0, bus.redirect_valid}, 32'd0);
        cyc(1, 0);
        chk("ovr_valid",     {31'd0, bus.redirect_valid}, 32'd1);
        chk("ovr_pc",        bus.redirect_pc, 32'h0000_4000);
        chk("ovr_flush_cnt", bus.flush_cnt, exp_fcnt);
        cyc(0, 0);
        chk("ovr_valid_once", {31'd0, bus.redirect_valid}, 32'd0);
    endtask

    task automatic test_branch_under_stall();
        bus.mem_stall_req = 1'b1; bus.ex_branch_taken = 1'b1;
        bus.ex_branch_target = 32'h0000_5000; bus.if_busy = 1'b0;
        for (int i = 0; i < 2; i++) begin
            #1;
            chk("bst_fif",   {31'd0, bus.flush_if_id}, 32'd0);
            chk("bst_fid",   {31'd0, bus.flush_id_ex}, 32'd0);
            chk("bst_stall", {27'd0, bus.stall}, 32'h0F);
            cyc(1, 0);
            chk("bst_flush_cnt", bus.flush_cnt, exp_fcnt);
            chk("bst_no_valid",  {31'd0, bus.redirect_valid}, 32'd0);
        end
        bus.mem_stall_req = 1'b0;
        #1;
        chk("bst_acc_fif", {31'd0, bus.flush_if_id}, 32'd1);
        chk("bst_acc_fid", {31'd0, bus.flush_id_ex}, 32'd1);
        exp_q.push_back(32'h0000_5000);
        cyc(0, 1);
        bus.ex_branch_taken = 1'b0;
        #1;
        chk("bst_valid",     {31'd0, bus.redirect_valid}, 32'd1);
        chk("bst_flush_cnt", bus.flush_cnt, exp_fcnt);
        cyc(0, 0);
    endtask

    task automatic test_freeze_and_reset();
        bus.ex_branch_taken = 1'b1; bus.ex_branch_target = 32'h0000_6000; bus.if_busy = 1'b1;
        cyc(0, 1);
        // Frozen: fetch completes and new requests arrive, none may take effect
        bus.rdy = 1'b0; bus.if_busy = 1'b0;
        bus.ex_branch_target = 32'h0000_7000; bus.mem_stall_req = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("frz_stall",   {27'd0, bus.stall}, 32'h1F);
            chk("frz_fif",     {31'd0, bus.flush_if_id}, 32'd0);
            chk("frz_fid",     {31'd0, bus.flush_id_ex}, 32'd0);
            chk("frz_valid",   {31'd0, bus.redirect_valid}, 32'd0);
            chk("frz_discard", {31'd0, bus.if_discard}, 32'd1);
            @(posedge clk); #1;
        end
        chk("frz_stall_cnt", bus.stall_cnt, exp_scnt);
        chk("frz_flush_cnt", bus.flush_cnt, exp_fcnt);
        chk("frz_pc",        bus.redirect_pc, 32'h0000_6000);
        bus.rdy = 1'b1; bus.if_busy = 1'b1;
        bus.ex_branch_taken = 1'b0; bus.mem_stall_req = 1'b0;
        #1;
        chk("frz_state_kept", {31'd0, bus.stall[0]}, 32'd1);
        cyc(1, 0);
        // Reset mid-PEND drops the pending redirect
        rst = 1'b1; bus.if_busy = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        exp_scnt = 32'd0; exp_fcnt = 32'd0;
        #1;
        chk("prst_stall",     {27'd0, bus.stall}, 32'd0);
        chk("prst_fif",       {31'd0, bus.flush_if_id}, 32'd0);
        chk("prst_discard",   {31'd0, bus.if_discard}, 32'd0);
        chk("prst_pc",        bus.redirect_pc, 32'd0);
        chk("prst_stall_cnt", bus.stall_cnt, 32'd0);
        chk("prst_flush_cnt", bus.flush_cnt, 32'd0);
        for (int i = 0; i < 3; i++) begin
            chk("prst_no_valid", {31'd0, bus.redirect_valid}, 32'd0);
            cyc(0, 0);
        end
    endtask

    initial begin
        test_reset();
        test_stall_priority();
        test_branch_idle();
        test_branch_pend();
        test_pend_overwrite();
        test_branch_under_stall();
        test_freeze_and_reset();
        @(negedge clk);
        chk("sb_all_redirects_seen", exp_q.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pipe_ctrl.md
# pipe_ctrl

Central pipeline sequencer for the five-stage core. It generates the per-register hold (stall) and bubble (flush) controls for the pc, if_id, id_ex, ex_mem and mem_wb pipeline registers from the stages' stall requests. It also owns branch redirection: it kills wrong-path instructions, defers the PC redirect while an instruction fetch is in flight, and tells IF to discard the stale fetch. Two performance counters expose stall and flush activity to the debug path.

## Interface
- No parameters; all widths are fixed (stall bus 5 bits, addresses 32 bits).
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- rdy  in  1  1 = core runs; 0 = freeze the whole pipeline
- if_stall_req  in  1  IF cannot deliver an instruction this cycle
- id_stall_req  in  1  ID hazard (load-use) this cycle
- ex_stall_req  in  1  EX multi-cycle operation busy
- mem_stall_req  in  1  MEM load/store not complete
- ex_branch_taken  in  1  EX resolved a taken branch or jump this cycle
- ex_branch_target  in  32  target PC for ex_branch_taken
- if_busy  in  1  IF has a memory fetch outstanding
- stall  out  5  hold enables; bit0 pc, bit1 if_id, bit2 id_ex, bit3 ex_mem, bit4 mem_wb
- flush_if_id  out  1  load NOP into if_id
- flush_id_ex  out  1  load NOP into id_ex (NON_OP, NOPRegAddr, WriteDisable)
- redirect_valid  out  1  one-cycle pulse: PC loads redirect_pc
- redirect_pc  out  32  redirect target
- if_discard  out  1  IF drops the instruction returned by its in-flight fetch
- stall_cnt  out  32  cycles with stall[0]=1 while rdy=1
- flush_cnt  out  32  number of accepted redirects

## Operation
- Stall vector (combinational, rdy=1): the deepest requester k wins. mem → 5'b01111; ex → 5'b00111; id → 5'b00011; if → 5'b00001; none → 0. Stages at or above k hold; stage k+1 advances.
- Bubble insertion:
  - id_stall_req as the deepest request → flush_id_ex=1, so EX receives a NOP.
  - if_stall_req as the deepest request → flush_if_id=1.
  - ex/mem requests insert no flush. The ex_mem/mem_wb bubble is produced by EX/MEM themselves.
- Redirect acceptance: ex_branch_taken && !stall[2] && rdy. On acceptance, in the same cycle:
  - flush_if_id=1 and flush_id_ex=1;
  - target latched into redirect_pc;
  - flush_cnt += 1.
- ex_branch_taken while stall[2]=1 is ignored. EX re-presents it on the next cycle.
- Redirect state machine, states IDLE and PEND:
  - IDLE, acceptance with if_busy=0 → redirect_valid=1 on the next cycle; stay IDLE.
  - IDLE, acceptance with if_busy=1 → PEND.
  - PEND: if_discard=1, flush_if_id=1, stall[0] forced to 1 (pc holds).
  - PEND with if_busy=0 → redirect_valid=1 on the next cycle; go to IDLE.
  - Acceptance while in PEND overwrites redirect_pc and stays in PEND.
- rdy=0:
  - stall=5'b11111, flush_*=0, redirect_valid=0;
  - if_discard holds its value;
  - no state, redirect_pc or counter updates.
- Counters wrap modulo 2^32.

## Timing
- stall and flush_* are combinational from the same-cycle requests.
- redirect_valid and if_discard are registered.
- Redirect latency:
  - 1 cycle after acceptance with if_busy=0;
  - otherwise 1 cycle after the first cycle with if_busy=0 in PEND.
- redirect_valid is never high for more than 1 cycle per accepted branch.
- Reset values: stall=0, flush_if_id=0, flush_id_ex=0, redirect_valid=0, redirect_pc=0, if_discard=0, stall_cnt=0, flush_cnt=0, state IDLE.
- Reset mid-PEND drops the pending redirect; no redirect_valid is issued.
- rst has priority over rdy.
- Simultaneous acceptance and if_busy falling in PEND → the new target is used; redirect_valid follows on the next cycle.

## Test plan
- mem_stall_req=1 with id_stall_req=1 and if_stall_req=1 → stall=5'b01111, flush_id_ex=0, flush_if_id=0. Drop mem only → stall=5'b00011, flush_id_ex=1.
- Taken branch, target 0x0000_1000, if_busy=0 → same cycle flush_if_id=flush_id_ex=1; next cycle redirect_valid=1 with redirect_pc=0x1000; flush_cnt=1.
- Taken branch to 0x2000 with if_busy=1 for 3 cycles:
  - if_discard=1 and stall[0]=1 for those cycles;
  - redirect_valid pulses exactly once, 1 cycle after if_busy falls.
- Branch in PEND to 0x3000, then second branch to 0x4000 before if_busy falls → one redirect pulse, redirect_pc=0x4000, flush_cnt=2.
- ex_branch_taken while mem_stall_req=1 → no flushes, no counter change. Accepted on the first cycle mem_stall_req=0.
- rdy=0 for 4 cycles during PEND → stall=5'b11111, counters frozen, state kept. rst during PEND → all outputs at reset values next cycle, no redirect_valid.
